// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg -- shared definitions for the FIFO-fed UART transmitter.
//   tx_state_e    : transmitter frame state (IDLE, START, DATA, STOP)
//   TX_IDLE_LEVEL : serial line level while no frame is in progress
//   START_LEVEL   : serial line level during the start bit
//   STOP_LEVEL    : serial line level during the stop bit
// -----------------------------------------------------------------------------
package fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam logic TX_IDLE_LEVEL = 1'b1;
  localparam logic START_LEVEL   = 1'b0;
  localparam logic STOP_LEVEL    = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx_if -- FIFO read side plus serial output of the UART transmitter.
//   en         : permits starting a new frame
//   pndng      : FIFO data-pending flag
//   din        : FIFO read data, valid whenever pndng=1
//   pop        : one-cycle FIFO read strobe
//   tx         : serial line, idle high
//   busy       : high while a frame is in progress
//   frame_done : one-cycle pulse in the last cycle of each stop bit
// Modports: master = FIFO/controller side, slave = transmitter.
// -----------------------------------------------------------------------------
interface fifo_uart_tx_if #(
  parameter int BITS = 8
) ();

  logic            en;
  logic            pndng;
  logic [BITS-1:0] din;
  logic            pop;
  logic            tx;
  logic            busy;
  logic            frame_done;

  modport master (
    output en, pndng, din,
    input  pop, tx, busy, frame_done
  );

  modport slave (
    input  en, pndng, din,
    output pop, tx, busy, frame_done
  );

endinterface

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// -----------------------------------------------------------------------------
// baud_tick_gen -- bit-period timer for the UART transmitter.
//   clk     : system clock, rising edge
//   rst     : asynchronous active-low reset
//   restart : holds the count at zero so the next period starts cleanly
//   tick    : high on the last cycle of each CLKS_PER_BIT-cycle bit period
// The counter reloads on every tick, so back-to-back periods need no restart.
// -----------------------------------------------------------------------------
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx -- UART transmitter reading words straight from a FIFO.
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : fifo_uart_tx_if.slave (en, pndng, din in; pop, tx, busy, frame_done out)
// Frame: one start bit, BITS data bits LSB first, one stop bit, each
// CLKS_PER_BIT cycles. A word is captured from IDLE or on the last stop cycle
// when en and pndng are both high, giving gap-free back-to-back frames.
// -----------------------------------------------------------------------------
module fifo_uart_tx
  import fifo_pkg::*;
#(
  parameter int BITS         = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic           clk,
  input  logic           rst,
  fifo_uart_tx_if.slave  bus
);

  localparam int                BIT_W    = $clog2(BITS + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BITS - 1);

  tx_state_e        state;
  tx_state_e        next_state;
  logic [BITS-1:0]  shreg;
  logic [BITS-1:0]  shreg_next;
  logic [BIT_W-1:0] bit_cnt;
  logic             tick;
  logic             baud_restart;
  logic             capture;
  logic             last_bit;
  logic             tx_d;
  logic             tx_q;
  logic             pop_q;

  // Timer sits at zero while idle so the start bit gets a full period.
  assign baud_restart = (state == ST_IDLE);

  baud_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (baud_restart),
    .tick    (tick)
  );

  // en/pndng only matter at the two capture opportunities; pndng gating
  // here is what makes a pop on an empty FIFO impossible.
  assign capture  = bus.en && bus.pndng &&
                    ((state == ST_IDLE) || ((state == ST_STOP) && tick));
  assign last_bit = (bit_cnt == LAST_BIT);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  // NOTE: the default assignment before the case keeps this purely
  // combinational; a missing path would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:  if (capture)           next_state = ST_START;
      ST_START: if (tick)              next_state = ST_DATA;
      ST_DATA:  if (tick && last_bit)  next_state = ST_STOP;
      ST_STOP:  if (tick)              next_state = capture ? ST_START : ST_IDLE;
      default:                         next_state = ST_IDLE;
    endcase
  end

  // Output logic: next shift-register value and the line level that goes
  // with next_state, so the registered tx lines up with the state register.
  always_comb begin
    shreg_next = shreg;
    tx_d       = TX_IDLE_LEVEL;
    if (capture) begin
      shreg_next = bus.din;
    end else if ((state == ST_DATA) && tick) begin
      shreg_next = {1'b0, shreg[BITS-1:1]};
    end
    unique case (next_state)
      ST_START: tx_d = START_LEVEL;
      ST_DATA:  tx_d = shreg_next[0];
      ST_STOP:  tx_d = STOP_LEVEL;
      default:  tx_d = TX_IDLE_LEVEL;
    endcase
  end

  // Datapath registers.
  // NOTE: the shift register and counters are ordinary flops, not a memory
  // array, so they take the async reset; an aborted word leaves no residue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      tx_q    <= TX_IDLE_LEVEL;
      pop_q   <= 1'b0;
    end else begin
      shreg <= shreg_next;
      tx_q  <= tx_d;
      pop_q <= capture;
      if (capture) begin
        bit_cnt <= '0;
      end else if ((state == ST_DATA) && tick) begin
        bit_cnt <= last_bit ? '0 : bit_cnt + BIT_W'(1);
      end
    end
  end

  assign bus.tx         = tx_q;
  assign bus.pop        = pop_q;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.frame_done = (state == ST_STOP) && tick;

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL take parameter BITS, default 8, as the data word width and serial data bits per frame.
REQ-002 The block SHALL take parameter CLKS_PER_BIT, default 16, as clk cycles per serial bit (legal range 2..65535).
REQ-003 The block SHALL have port clk, input, 1 bit, the system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the reset: asynchronous, active-low.
REQ-005 The block SHALL have port en, input, 1 bit, which permits starting a new frame.
REQ-006 The block SHALL have port pndng, input, 1 bit, the FIFO data-pending flag.
REQ-007 The block SHALL have port din, input, BITS bits, the FIFO read data, valid whenever pndng=1.
REQ-008 The block SHALL have port pop, output, 1 bit, a registered one-cycle FIFO read strobe.
REQ-009 The block SHALL have port tx, output, 1 bit, the serial line, idle high.
REQ-010 The block SHALL have port busy, output, 1 bit, high while a frame is in progress.
REQ-011 The block SHALL have port frame_done, output, 1 bit, a one-cycle pulse in the last cycle of each stop bit.

Function
REQ-012 The block SHALL implement the states IDLE, START, DATA and STOP; busy=1 in every state except IDLE.
REQ-013 In IDLE, on the edge where en=1 and pndng=1, the block SHALL capture din into the shift register and enter START.
REQ-014 The block SHALL drive pop=1 for exactly the one cycle following each capture edge, and never otherwise.
REQ-015 The block SHALL drive tx=0 in START, shift-register bit 0 in DATA, and tx=1 in STOP and IDLE; tx is registered.
REQ-016 Each of START, each data bit, and STOP SHALL last exactly CLKS_PER_BIT cycles, timed by a counter that reloads on every bit boundary.
REQ-017 The block SHALL send data LSB first: exactly BITS data bits, with the shift register shifting right once per bit boundary.
REQ-018 A frame SHALL be exactly (BITS+2)*CLKS_PER_BIT cycles long, measured from the first START cycle to the last STOP cycle.
REQ-019 On the last STOP cycle, if en=1 and pndng=1, the block SHALL capture din and go directly to START with no idle cycle; otherwise it SHALL go to IDLE.
REQ-020 The block SHALL sample en and pndng only at capture opportunities; changes mid-frame SHALL NOT affect the frame in progress.
REQ-021 When pndng=0, the block SHALL never assert pop, so that underflow is impossible.
REQ-022 The block SHALL size the bit counter at $clog2(BITS+1) bits and the baud counter at $clog2(CLKS_PER_BIT) bits, with no wrap beyond the terminal count.

Reset
REQ-023 While rst=0, the block SHALL force state=IDLE, tx=1, pop=0, busy=0, frame_done=0, and clear all counters and the shift register.
REQ-024 If rst is asserted mid-frame, the block SHALL abort the frame immediately and SHALL NOT pop again for the aborted word.
REQ-025 After rst deasserts, the block SHALL make its first capture no earlier than the first rising clk edge.

Structure
REQ-026 The state enumeration and the TX_IDLE_LEVEL/START_LEVEL/STOP_LEVEL constants SHALL live in the shared package fifo_pkg.
REQ-027 Bit timing SHALL be a sub-module baud_tick_gen (params CLKS_PER_BIT; ports clk, rst, restart, tick) that pulses tick on the last cycle of each bit period.
REQ-028 The block SHALL connect directly to fifo Dout/pndng/pop with no glue logic.

Verification
REQ-029 Reset: hold rst=0 with pndng=1 -> tx=1, pop=0, busy=0 throughout; after release, capture occurs on the first edge.
REQ-030 Single word: BITS=8, CLKS_PER_BIT=4, din=0xA5, pndng for 1 cycle -> one pop pulse; tx shows 0 then 1,0,1,0,0,1,0,1 then 1, each held 4 cycles; 40-cycle frame; frame_done at cycle 40.
REQ-031 Back-to-back: 3 words 0x01, 0x80, 0xFF queued -> 3 pops spaced 40 cycles apart; 120 contiguous frame cycles with no idle gap; busy stays high.
REQ-032 Gating: en=0 with pndng=1 -> no pop and tx stays 1; raise en -> frame starts on the next edge.
REQ-033 Mid-frame abort: assert rst in DATA bit 3 -> tx=1 immediately; after release with the FIFO empty, no further pop occurs.
REQ-034 Slow divider: CLKS_PER_BIT=2, din=0x00 -> tx low for 18 cycles, then high for 2; frame_done is one cycle wide.
